pwl_act_simd: RTL and testbench

Multi-lane, runtime-programmable piecewise-linear (PWL) activation unit for fp32 operands. It is the successor to the fixed-GELU LUT unit and adds three things: a loadable breakpoint table, per-beat symmetry mode (GELU/SiLU, tanh, sigmoid-type), and `LANES` parallel lanes. The pipeline uses a valid/ready handshake with full backpressure. It sits between the vector datapath and the activation writeback in the FPU cluster.

---
 rtl/pwl_act_simd.sv | 219 +++++++++++++++++++++
 tb/tb_pwl_act_simd.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_act_simd.sv
// Multi-lane runtime-programmable piecewise-linear fp32 activation unit, 4-stage valid/ready pipeline.
// Optional macro PWL_ACT_SPECIAL_EN: decode NaN/inf inputs (canonical NaN out, inf as out-of-range).
module pwl_act_simd #(
  parameter int LANES     = 4,
  parameter int LUT_SIZE  = 32,
  parameter int LUT_BITS  = 16,
  parameter int LUT_FRAC  = 12,
  parameter int X_MAX_EXP = 2,
  parameter int T_BITS    = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [32*LANES-1:0]             in_data,
  input  logic [1:0]                      in_mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [32*LANES-1:0]             out_data,
  input  logic                            cfg_we,
  input  logic [$clog2(LUT_SIZE+1)-1:0]   cfg_addr,
  input  logic [LUT_BITS-1:0]             cfg_data,
  output logic                            busy
);

  localparam int AW = $clog2(LUT_SIZE + 1);
  localparam int IW = $clog2(LUT_SIZE);
  localparam int UW = IW + T_BITS;
  localparam int QW = X_MAX_EXP + LUT_FRAC;
  localparam int DW = LUT_BITS + 1;
  localparam int YW = LUT_BITS + X_MAX_EXP + 2;
  localparam int MW = $clog2(YW);
  // Mantissa is pre-shifted left by 32 so both shifts below are right shifts for every in-range exponent.
  localparam int U_SH = 127 + 23 + 32 + X_MAX_EXP - IW - T_BITS;
  localparam int A_SH = 127 + 23 + 32 - LUT_FRAC;
  localparam logic [7:0] OOR_EXP = 8'(127 + X_MAX_EXP);
  localparam logic [1:0] MODE_SHIFT_X = 2'b01;
  localparam logic [1:0] MODE_ONE     = 2'b10;
  localparam logic signed [YW-1:0] ONE_Q = YW'(1 << LUT_FRAC);

  logic signed [LUT_BITS-1:0] lut_mem [LUT_SIZE+1];

  logic       stall;
  logic       valid_s0_reg, valid_s1_reg, valid_s2_reg, out_valid_reg;
  logic [1:0] mode_s0_reg, mode_s1_reg;

  assign stall     = out_valid_reg && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_valid_reg;
  assign busy      = valid_s0_reg | valid_s1_reg | valid_s2_reg | out_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LUT_SIZE; k++) lut_mem[k] <= '0;
    end else if (cfg_we && (cfg_addr <= AW'(LUT_SIZE))) begin
      lut_mem[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s0_reg  <= 1'b0;
      valid_s1_reg  <= 1'b0;
      valid_s2_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      mode_s0_reg   <= 2'b00;
      mode_s1_reg   <= 2'b00;
    end else if (!stall) begin
      valid_s0_reg  <= in_valid;
      valid_s1_reg  <= valid_s0_reg;
      valid_s2_reg  <= valid_s1_reg;
      out_valid_reg <= valid_s2_reg;
      mode_s0_reg   <= in_mode;
      mode_s1_reg   <= mode_s0_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [31:0]         lane_x;
      logic [7:0]          x_exp;
      logic [23:0]         mant;
      logic [8:0]          sh_u, sh_a;
      logic                nan_c, oor_c;
      logic [UW-1:0]       u_c;
      logic [QW-1:0]       aq_c;
      logic [IW-1:0]       idx_c;
      logic [T_BITS-1:0]   t_c;
      logic [AW-1:0]       rd_idx, rd_idx1;

      logic                       s0_sign_reg, s0_oor_reg, s0_nan_reg;
      logic [T_BITS-1:0]          s0_t_reg;
      logic [QW-1:0]              s0_aq_reg;
      logic [31:0]                s0_abs_reg;
      logic signed [LUT_BITS-1:0] s0_y0_reg, s0_y1_reg;

      logic                       s1_sign_reg, s1_oor_reg, s1_nan_reg;
      logic [T_BITS-1:0]          s1_t_reg;
      logic [QW-1:0]              s1_aq_reg;
      logic [31:0]                s1_abs_reg;
      logic signed [LUT_BITS-1:0] s1_y0_reg;
      logic signed [DW-1:0]       s1_d_reg;

      logic signed [DW+T_BITS:0]  prod;
      logic signed [YW-1:0]       y_int, y_res;
      logic                       byp;
      logic [31:0]                byp_val;

      logic signed [YW-1:0]       s2_res_reg;
      logic                       s2_byp_reg;
      logic [31:0]                s2_byp_val_reg;

      logic                       neg;
      logic [YW-1:0]              mag;
      logic [MW-1:0]              msb;
      logic [31:0]                fp;
      logic [31:0]                lane_out_reg;

      assign lane_x = in_data[32*gi +: 32];

      always_comb begin
        x_exp = lane_x[30:23];
        mant  = (x_exp == 8'd0) ? 24'd0 : {1'b1, lane_x[22:0]};
`ifdef PWL_ACT_SPECIAL_EN
        nan_c = (x_exp == 8'hFF) && (lane_x[22:0] != 23'd0);
`else
        nan_c = 1'b0;
`endif
        oor_c   = (x_exp >= OOR_EXP) && !nan_c;
        sh_u    = 9'(U_SH - int'(x_exp));
        sh_a    = 9'(A_SH - int'(x_exp));
        u_c     = UW'({mant, 32'd0} >> sh_u);
        aq_c    = QW'({mant, 32'd0} >> sh_a);
        // Out-of-range lanes read T[LUT_SIZE-1..LUT_SIZE]; stage 1 then selects the top entry.
        idx_c   = oor_c ? '1 : u_c[UW-1:T_BITS];
        t_c     = oor_c ? '0 : u_c[T_BITS-1:0];
        rd_idx  = AW'(idx_c);
        rd_idx1 = AW'(idx_c) + AW'(1);
      end

      always_comb begin
        prod  = s1_d_reg * $signed({1'b0, s1_t_reg});
        y_int = YW'(s1_y0_reg) + YW'(prod >>> T_BITS);
        y_res = y_int;
        if (s1_sign_reg) begin
          case (mode_s1_reg)
            MODE_SHIFT_X: y_res = s1_oor_reg ? '0 : y_int - $signed(YW'(s1_aq_reg));
            MODE_ONE:     y_res = ONE_Q - y_int;
            default:      y_res = -y_int;
          endcase
        end
        byp     = s1_nan_reg || ((mode_s1_reg == MODE_SHIFT_X) && s1_oor_reg && !s1_sign_reg);
        byp_val = s1_nan_reg ? 32'h7FC0_0000 : s1_abs_reg;
      end

      always_comb begin
        neg = s2_res_reg[YW-1];
        mag = neg ? -s2_res_reg : s2_res_reg;
        msb = '0;
        for (int b = 0; b < YW; b++) begin
          if (mag[b]) msb = MW'(b);
        end
        fp = '0;
        if (mag != '0) begin
          fp = {neg, 8'(127 + int'(msb) - LUT_FRAC), 23'(32'(mag) << (23 - int'(msb)))};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s0_sign_reg    <= 1'b0;
          s0_oor_reg     <= 1'b0;
          s0_nan_reg     <= 1'b0;
          s0_t_reg       <= '0;
          s0_aq_reg      <= '0;
          s0_abs_reg     <= '0;
          s0_y0_reg      <= '0;
          s0_y1_reg      <= '0;
          s1_sign_reg    <= 1'b0;
          s1_oor_reg     <= 1'b0;
          s1_nan_reg     <= 1'b0;
          s1_t_reg       <= '0;
          s1_aq_reg      <= '0;
          s1_abs_reg     <= '0;
          s1_y0_reg      <= '0;
          s1_d_reg       <= '0;
          s2_res_reg     <= '0;
          s2_byp_reg     <= 1'b0;
          s2_byp_val_reg <= '0;
          lane_out_reg   <= '0;
        end else if (!stall) begin
          s0_sign_reg    <= lane_x[31];
          s0_oor_reg     <= oor_c;
          s0_nan_reg     <= nan_c;
          s0_t_reg       <= t_c;
          s0_aq_reg      <= aq_c;
          s0_abs_reg     <= {1'b0, lane_x[30:0]};
          s0_y0_reg      <= lut_mem[rd_idx];
          s0_y1_reg      <= lut_mem[rd_idx1];
          s1_sign_reg    <= s0_sign_reg;
          s1_oor_reg     <= s0_oor_reg;
          s1_nan_reg     <= s0_nan_reg;
          s1_t_reg       <= s0_t_reg;
          s1_aq_reg      <= s0_aq_reg;
          s1_abs_reg     <= s0_abs_reg;
          s1_y0_reg      <= s0_oor_reg ? s0_y1_reg : s0_y0_reg;
          s1_d_reg       <= s0_oor_reg ? '0 : DW'(s0_y1_reg) - DW'(s0_y0_reg);
          s2_res_reg     <= y_res;
          s2_byp_reg     <= byp;
          s2_byp_val_reg <= byp_val;
          lane_out_reg   <= s2_byp_reg ? s2_byp_val_reg : fp;
        end
      end

      assign out_data[32*gi +: 32] = lane_out_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pwl_act_simd.sv
// Scoreboard bench for pwl_act_simd with an identity table T[k] = k*512.
module tb_pwl_act_simd;
  localparam int LANES = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         cfg_we;
  logic [5:0]   cfg_addr;
  logic [15:0]  cfg_data;
  logic         busy;

  always #5 clk = ~clk;

  pwl_act_simd dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy)
  );

  logic [127:0] sb_q[$];
  int checks = 0;
  int errors = 0;
  int rx_count = 0;
  real pool [12];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real m;
    int  e;
    logic s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  // Behavioural expectation for the identity table (exact for the pool values).
  function automatic logic [31:0] exp_lane(input real x, input logic [1:0] m);
    real a, r;
    logic s;
    s = (x < 0.0);
    a = s ? -x : x;
    r = 0.0;
    if (a >= 4.0) begin
      case (m)
        2'b01: begin if (s) return 32'h0; return r2f(a); end
        2'b10: r = s ? -3.0 : 4.0;
        default: r = s ? -4.0 : 4.0;
      endcase
    end else begin
      case (m)
        2'b01: r = s ? 0.0 : a;
        2'b10: r = s ? 1.0 - a : a;
        default: r = s ? -a : a;
      endcase
    end
    return r2f(r);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      rx_count++;
      chk("beat_expected", 128'(sb_q.size() > 0), 128'd1);
      if (sb_q.size() > 0) chk("out_beat", out_data, sb_q.pop_front());
    end
  end

  task automatic send(input logic [127:0] d, input logic [1:0] m, input logic [127:0] e);
    int  n;
    logic ok;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    ok = 1'b0;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    if (!ok) begin
      chk("send_timeout", 128'(ok), 128'd1);
      #1 in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 128'(sb_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rx0;
    logic [127:0] d, e, held;
    logic [1:0] m;

    pool = '{1.0, 1.25, 1.0625, -1.0, -0.5, 2.375, -3.75, 5.0, -5.0, 0.125, -2.0, 3.5};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'b00; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;

    // Identity table.
    for (int k = 0; k <= 32; k++) begin
      cfg_we = 1'b1; cfg_addr = 6'(k); cfg_data = 16'(k * 512);
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;

    // Latency and exact/interpolated points (mode ODD).
    d = pack4(32'h3F800000, 32'h3FA00000, 32'h3F880000, 32'hBF800000);
    in_valid = 1'b1; in_data = d; in_mode = 2'b00;
    @(posedge clk);
    sb_q.push_back(d);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("latency", 128'(lat), 128'd4);
    @(posedge clk); #1;
    drain();

    // SHIFT_X symmetry and out-of-range.
    send(pack4(32'hBF800000, 32'h40A00000, 32'hC0A00000, 32'h3F800000), 2'b01,
         pack4(32'h00000000, 32'h40A00000, 32'h00000000, 32'h3F800000));
    // ONE symmetry and saturation.
    send(pack4(32'hC0A00000, 32'h3F800000, 32'hBF000000, 32'h40A00000), 2'b10,
         pack4(32'hC0400000, 32'h3F800000, 32'h3F000000, 32'h40800000));
    // ODD saturation, zero and denormal.
    send(pack4(32'h40A00000, 32'hC0A00000, 32'h00000000, 32'h00000001), 2'b00,
         pack4(32'h40800000, 32'hC0800000, 32'h00000000, 32'h00000000));
    // Mode 11 behaves as ODD.
    send(pack4(32'hBF800000, 32'h3FA00000, 32'hBFA00000, 32'h3E000000), 2'b11,
         pack4(32'hBF800000, 32'h3FA00000, 32'hBFA00000, 32'h3E000000));
    // Exponent 0xFF inputs.
`ifdef PWL_ACT_SPECIAL_EN
    send(pack4(32'h7FC00001, 32'h7F800000, 32'hFF800000, 32'hFFC00000), 2'b00,
         pack4(32'h7FC00000, 32'h40800000, 32'hC0800000, 32'h7FC00000));
`else
    send(pack4(32'h7FC00001, 32'h7F800000, 32'hFF800000, 32'hFFC00000), 2'b00,
         pack4(32'h40800000, 32'h40800000, 32'hC0800000, 32'hC0800000));
`endif
    send(pack4(32'h7F800000, 32'hFF800000, 32'h3F800000, 32'hBF800000), 2'b01,
         pack4(32'h7F800000, 32'h00000000, 32'h3F800000, 32'h00000000));
    drain();

    // Backpressure: six back-to-back beats, out_ready low in cycles 5-7.
    rx0 = rx_count;
    fork
      begin
        for (int j = 0; j < 6; j++) begin
          logic [127:0] dj, ej;
          logic [1:0]   mj;
          mj = 2'(j % 3);
          for (int i = 0; i < LANES; i++) begin
            dj[32*i +: 32] = r2f(pool[(j * 5 + i) % 12]);
            ej[32*i +: 32] = exp_lane(pool[(j * 5 + i) % 12], mj);
          end
          send(dj, mj, ej);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("stall_in_ready", 128'(in_ready), 128'd0);
          chk("stall_out_valid", 128'(out_valid), 128'd1);
          if (c == 0) held = out_data;
          else chk("stall_data_stable", out_data, held);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_beat_count", 128'(rx_count - rx0), 128'd6);

    // Table update: T[8]=0 written in the cycle the first beat is issued.
    cfg_we = 1'b1; cfg_addr = 6'd8; cfg_data = 16'd0;
    e = pack4(32'h3F800000, 32'h3F800000, 32'h3F880000, 32'h3FA00000);
    send(pack4(32'h3F800000, 32'h3F800000, 32'h3F880000, 32'h3FA00000), 2'b00, e);
    cfg_we = 1'b0;
    send(pack4(32'h3F800000, 32'h3F800000, 32'h3F880000, 32'h3FA00000), 2'b00,
         pack4(32'h00000000, 32'h00000000, 32'h3F100000, 32'h3FA00000));
    drain();

    // Reset with three beats in flight.
    m = 2'b00;
    for (int j = 0; j < 3; j++) send(pack4(32'h3F800000, 32'h3FA00000, 32'h3F880000, 32'hBF800000), m,
                                     pack4(32'h3F800000, 32'h3FA00000, 32'h3F880000, 32'hBF800000));
    chk("inflight_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_valid_busy", 128'({out_valid, busy}), 128'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
